// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared types and constants for the ALU front-panel sequencer
package alu_seq_pkg;

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_NOT = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_OR  = 3'd4;
    localparam logic [2:0] OP_XOR = 3'd5;
    localparam logic [2:0] OP_LT  = 3'd6;
    localparam logic [2:0] OP_EQ  = 3'd7;

    localparam int BTN_LOAD = 0;
    localparam int BTN_INC  = 1;
    localparam int BTN_DEC  = 2;
    localparam int BTN_EXEC = 3;
    localparam int BTN_CLR  = 4;
    localparam int BTN_N    = 5;

    localparam int DISP_OPA_LSB = 28;
    localparam int DISP_OPB_LSB = 24;
    localparam int DISP_OP_LSB  = 20;
    localparam int DISP_FLG_LSB = 16;
    localparam int DISP_RES_LSB = 12;
    localparam int DISP_CNT_LSB = 0;

    function automatic logic [31:0] pack_disp(input logic [3:0] a, input logic [3:0] b,
                                              input logic [2:0] op, input logic [2:0] flg,
                                              input logic [3:0] res, input logic [11:0] cnt);
        return {a, b, 1'b0, op, 1'b0, flg, res, cnt};
    endfunction

endpackage

// File: rtl/alu_seq_ctrl_btn_debounce.sv
// rtl/alu_seq_ctrl_btn_debounce.sv - 2-flop synchronizer, stability debouncer and rising-edge pulse
module btn_debounce #(
    parameter int DEB_W   = 16,
    parameter int DEB_CNT = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise
);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CNT - 1);

    logic [1:0]       r_sync;
    logic [DEB_W-1:0] r_cnt;
    logic             r_level;
    logic             r_rise;

    // r_cnt counts consecutive cycles where the synchronized input disagrees with r_level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync  <= 2'b00;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], raw};
            r_rise <= 1'b0;
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == DEB_LAST) begin
                r_cnt   <= '0;
                r_level <= r_sync[1];
                r_rise  <= r_sync[1];
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign level = r_level;
    assign rise  = r_rise;

endmodule

// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - front-panel sequencer for the 4-bit ALU; optional macro ALU_CHAIN_EN chains results into operand A
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int DEB_W   = 16,
    parameter int DEB_CNT = 50000,
    parameter int SETTLE  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  btn,
    input  logic [7:0]  sw,
    output logic [3:0]  alu_a,
    output logic [3:0]  alu_b,
    output logic [2:0]  alu_op,
    input  logic [3:0]  alu_out,
    input  logic        alu_zero,
    input  logic        alu_overflow,
    input  logic        alu_carry,
    output logic        busy,
    output logic        valid,
    output logic [31:0] disp_data
);
    localparam int SETTLE_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE - 1);

    logic [BTN_N-1:0] w_rise;
    logic [BTN_N-1:0] w_level_unused;

    for (genvar gi = 0; gi < BTN_N; gi++) begin : g_btn
        btn_debounce #(.DEB_W(DEB_W), .DEB_CNT(DEB_CNT)) u_deb (
            .clk   (clk),
            .rst   (rst),
            .raw   (btn[gi]),
            .level (w_level_unused[gi]),
            .rise  (w_rise[gi])
        );
    end

    logic [7:0]          r_sw_s1, r_sw_s2;
    state_t              r_state;
    logic [SETTLE_W-1:0] r_settle;
    logic [3:0]          r_op_a, r_op_b, r_res;
    logic [2:0]          r_op, r_flg;
    logic [11:0]         r_cnt;
    logic                r_busy, r_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sw_s1 <= '0;
            r_sw_s2 <= '0;
        end else begin
            r_sw_s1 <= sw;
            r_sw_s2 <= r_sw_s1;
        end
    end

    // Soft clear outranks everything and keeps only the execution counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_settle <= '0;
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_op     <= OP_ADD;
            r_res    <= '0;
            r_flg    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_valid  <= 1'b0;
        end else if (w_rise[BTN_CLR]) begin
            r_state  <= IDLE;
            r_settle <= '0;
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_op     <= OP_ADD;
            r_res    <= '0;
            r_flg    <= '0;
            r_busy   <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_rise[BTN_LOAD]) begin
                        r_op_a  <= r_sw_s2[7:4];
                        r_op_b  <= r_sw_s2[3:0];
                        r_valid <= 1'b0;
                    end
                    if (w_rise[BTN_INC] ^ w_rise[BTN_DEC]) begin
                        r_op    <= w_rise[BTN_INC] ? r_op + 3'd1 : r_op - 3'd1;
                        r_valid <= 1'b0;
                    end
                    if (w_rise[BTN_EXEC]) begin
                        r_state  <= RUN;
                        r_settle <= SETTLE_LOAD;
                        r_busy   <= 1'b1;
                    end
                end
                RUN: begin
                    if (r_settle == '0) begin
                        r_res   <= alu_out;
                        r_flg   <= {alu_zero, alu_overflow, alu_carry};
                        r_cnt   <= r_cnt + 12'd1;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
`ifdef ALU_CHAIN_EN
                        r_op_a  <= alu_out;
`else
                        r_op_a  <= r_op_a;
`endif
                    end else begin
                        r_settle <= r_settle - 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign alu_a     = r_op_a;
    assign alu_b     = r_op_b;
    assign alu_op    = r_op;
    assign busy      = r_busy;
    assign valid     = r_valid;
    assign disp_data = pack_disp(r_op_a, r_op_b, r_op, r_flg, r_res, r_cnt);

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb/tb_alu_seq_ctrl.sv - self-checking bench for alu_seq_ctrl with a behavioural ALU and panel model
module tb_alu_seq_ctrl;
    localparam int DEB_CNT = 4;
    localparam int SETTLE  = 2;
    localparam int HOLD    = DEB_CNT + 6;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  btn;
    logic [7:0]  sw;
    logic [3:0]  alu_a, alu_b, alu_out;
    logic [2:0]  alu_op;
    logic        alu_zero, alu_overflow, alu_carry;
    logic        busy, valid;
    logic [31:0] disp_data;

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0]  m_a, m_b, m_res;
    logic [2:0]  m_op, m_flg;
    logic [11:0] m_cnt;
    logic        m_valid;

    alu_seq_ctrl #(.DEB_W(16), .DEB_CNT(DEB_CNT), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst(rst), .btn(btn), .sw(sw),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_out(alu_out), .alu_zero(alu_zero), .alu_overflow(alu_overflow), .alu_carry(alu_carry),
        .busy(busy), .valid(valid), .disp_data(disp_data)
    );

    always #5 clk = ~clk;

    // ALU stub: returns {result, zero, overflow, carry}; overflow is unsigned (add carry / sub borrow)
    function automatic logic [6:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        logic [4:0] s;
        logic [3:0] r;
        logic o, c;
        o = 1'b0; c = 1'b0; r = 4'd0;
        case (op)
            3'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[3:0]; c = s[4]; o = s[4]; end
            3'd1: begin s = {1'b0, a} + {1'b0, ~b} + 5'd1; r = s[3:0]; c = s[4]; o = ~s[4]; end
            3'd2: r = ~a;
            3'd3: r = a & b;
            3'd4: r = a | b;
            3'd5: r = a ^ b;
            3'd6: r = (a < b) ? 4'd1 : 4'd0;
            default: r = (a == b) ? 4'd1 : 4'd0;
        endcase
        return {r, (r == 4'd0), o, c};
    endfunction

    assign {alu_out, alu_zero, alu_overflow, alu_carry} = alu_f(alu_a, alu_b, alu_op);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".disp"}, disp_data, {m_a, m_b, 1'b0, m_op, 1'b0, m_flg, m_res, m_cnt});
        chk({tag, ".valid"}, 32'(valid), 32'(m_valid));
        chk({tag, ".busy"}, 32'(busy), 32'd0);
        chk({tag, ".alu_in"}, {21'd0, alu_a, alu_b, alu_op}, {21'd0, m_a, m_b, m_op});
    endtask

    task automatic model_zero(input logic keep_cnt);
        m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_flg = 0; m_valid = 0;
        if (!keep_cnt) m_cnt = 0;
    endtask

    task automatic model_exec();
        logic [6:0] r;
        r = alu_f(m_a, m_b, m_op);
        m_res = r[6:3];
        m_flg = r[2:0];
        m_cnt = m_cnt + 12'd1;
        m_valid = 1'b1;
`ifdef ALU_CHAIN_EN
        m_a = r[6:3];
`endif
    endtask

    task automatic press(input logic [4:0] bits);
        btn = bits;
        repeat (HOLD) tick();
        btn = 5'd0;
        repeat (HOLD) tick();
    endtask

    task automatic do_load(input logic [7:0] v);
        sw = v;
        press(5'b00001);
        m_a = v[7:4]; m_b = v[3:0]; m_valid = 0;
    endtask

    task automatic do_inc();
        press(5'b00010);
        m_op = m_op + 3'd1; m_valid = 0;
    endtask

    task automatic do_dec();
        press(5'b00100);
        m_op = m_op - 3'd1; m_valid = 0;
    endtask

    // Busy must stay high for exactly SETTLE cycles, with valid rising as busy falls
    task automatic do_exec();
        int w, nb;
        btn = 5'b01000;
        w = 0;
        while (!busy && w < 40) begin tick(); w++; end
        chk("exec.busy_seen", 32'(busy), 32'd1);
        nb = 0;
        while (busy && nb < 40) begin tick(); nb++; end
        chk("exec.settle", 32'(nb), 32'(SETTLE));
        chk("exec.valid_rise", 32'(valid), 32'd1);
        repeat (HOLD) tick();
        btn = 5'd0;
        repeat (HOLD) tick();
        model_exec();
    endtask

    logic [3:0] exp_res [3];

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; btn = 5'd0; sw = 8'd0;
        model_zero(1'b0);
        repeat (3) tick();
        check_all("reset");
        rst = 1'b0;
        tick();

        do_load(8'h35);
        check_all("load35");
        do_exec();
        check_all("exec_add");
        chk("add.fields", disp_data[31:12], 20'h35008);
        chk("add.cnt", 32'(disp_data[11:0]), 32'd1);

        btn = 5'b00010; tick(); tick();
        btn = 5'd0; repeat (HOLD) tick();
        check_all("glitch");
        btn = 5'b00010; repeat (10) tick();
        btn = 5'd0; repeat (HOLD) tick();
        m_op = m_op + 3'd1; m_valid = 0;
        check_all("held10");
        chk("held10.op", 32'(alu_op), 32'd1);

        do_dec();
        check_all("dec1");
        do_dec();
        check_all("dec_wrap");
        chk("dec_wrap.op", 32'(alu_op), 32'd7);
        do_inc();
        check_all("inc_wrap");
        chk("inc_wrap.op", 32'(alu_op), 32'd0);
        press(5'b00110);
        check_all("inc_dec_same");

        do_load(8'h77);
        do_inc();
        do_exec();
        check_all("sub77");
        chk("sub77.res_flg", {28'd0, disp_data[19:16]}, 32'h5);
        chk("sub77.res", 32'(disp_data[15:12]), 32'd0);
        do_load(8'h12);
        check_all("load_clears_valid");

        // load and op+1 pulses land one cycle after exec, inside RUN
        sw = 8'hAB;
        btn = 5'b01000; tick();
        btn = 5'b01011;
        repeat (HOLD) tick();
        btn = 5'd0; repeat (HOLD) tick();
        model_exec();
        check_all("run_discard");

        btn = 5'b01000; tick();
        btn = 5'b11000;
        repeat (HOLD) tick();
        btn = 5'd0; repeat (HOLD) tick();
        model_zero(1'b1);
        check_all("clear_in_run");

        do_load(8'h59);
        btn = 5'b01000;
        for (int i = 0; i < 40 && !busy; i++) tick();
        chk("rst_run.busy_seen", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        model_zero(1'b0);
        chk("rst_run.disp", disp_data, 32'd0);
        chk("rst_run.flags", {29'd0, busy, valid, 1'b0}, 32'd0);
        btn = 5'd0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check_all("after_rst");

`ifdef ALU_CHAIN_EN
        exp_res = '{4'd2, 4'd3, 4'd4};
`else
        exp_res = '{4'd2, 4'd2, 4'd2};
`endif
        do_load(8'h11);
        for (int k = 0; k < 3; k++) begin
            do_exec();
            check_all("chain");
            chk("chain.res", 32'(disp_data[15:12]), 32'(exp_res[k]));
        end

        for (int k = 0; k < 24; k++) begin
            case ($urandom_range(0, 3))
                0: do_load(8'($urandom));
                1: do_inc();
                2: do_dec();
                default: do_exec();
            endcase
            check_all("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
